// File: rtl/prg_ray_buffer.sv
// rtl/prg_ray_buffer.sv - ray FIFO between primary ray generator and traversal, with frame tracking (optional rayID check: PRG_RAY_BUFFER_SEQ_CHK_EN)
module prg_ray_buffer #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    parameter int NUM_RAYS     = 307200,
    parameter int ORIGIN_W     = 96,
    parameter int DIR_W        = 96,
    localparam int RAY_W       = 19 + ORIGIN_W + DIR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic [RAY_W-1:0] in_ray,
    output logic             out_valid,
    output logic [RAY_W-1:0] out_ray,
    input  logic             out_stall,
    output logic             almost_full,
    output logic             overflow,
    output logic [18:0]      ray_count,
    output logic             frame_done,
    output logic             seq_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [18:0] LAST_RAY = 19'(NUM_RAYS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [RAY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             enq;
    logic             deq;
    logic             drop;
    logic [18:0]      head_id;
    state_t           state;
    state_t           state_nxt;
    logic             count_en;
    logic             done_hit;

    // FIFO status and handshake; the head word is forced to zero while empty
    assign full        = (occupancy == CNT_W'(DEPTH));
    assign out_valid   = (occupancy != '0);
    assign out_ray     = out_valid ? mem[rd_ptr] : '0;
    assign head_id     = out_ray[RAY_W-1 -: 19];
    assign deq         = out_valid && !out_stall;
    assign enq         = in_valid && (!full || deq);
    assign drop        = in_valid && full && !deq;
    assign almost_full = (occupancy >= CNT_W'(DEPTH - AFULL_MARGIN));

    // Storage array; only the write port is clocked, reads fall through combinationally
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_ray;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state; frame_start overrides counting and completion in the same cycle
    always_comb begin
        state_nxt = state;
        count_en  = 1'b0;
        done_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!frame_start && deq) begin
                    count_en = 1'b1;
                    if (ray_count == LAST_RAY) begin
                        done_hit  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-frame delivery counter, completion pulse and sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ray_count  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= done_hit;
            if (frame_start || done_hit) begin
                ray_count <= '0;
            end else if (count_en) begin
                ray_count <= ray_count + 19'd1;
            end
            // A drop in the frame_start cycle belongs to the new frame, so it still sets the flag
            if (drop) begin
                overflow <= 1'b1;
            end else if (frame_start) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef PRG_RAY_BUFFER_SEQ_CHK_EN
    // Sticky ordering check: each counted ray must carry the rayID equal to its position in the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_err <= 1'b0;
        end else if (frame_start) begin
            seq_err <= 1'b0;
        end else if (count_en && (head_id != ray_count)) begin
            seq_err <= 1'b1;
        end
    end
`else
    // Ordering check not built
    assign seq_err = 1'b0;
    logic unused_head_id;
    assign unused_head_id = ^head_id;
`endif

endmodule
